fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  - IF stage directly upstream of the IF/ID pipeline register.
//  - Owns the architectural fetch PC and issues one instruction-memory request at a time over a req/ack handshake.
//  - Presents {instr_f, pc_f, pc_plus_8_f, valid_f} to IF/ID and honours stall and branch-redirect from ID.
//  - The top level drives IF/ID enable = ~stall_f and IF/ID clr = ~valid_f | redirect_d.
// PARAMETERS
//  PC_WIDTH     32  width of all PC/address values
//  INSTR_WIDTH  32  instruction word width
//  RESET_PC     0   first fetch address after reset
//  PC_STEP      4   byte increment between sequential fetches
// PORTS
//  clk            in   1            rising-edge clock
//  reset          in   1            asynchronous, active-high reset
//  stall_f        in   1            downstream hold: output slot must not be consumed
//  redirect_d     in   1            ID-stage taken branch/jump: flush and refetch
//  redirect_pc_d  in   PC_WIDTH     redirect target; bits [1:0] are ignored (forced 0)
//  imem_req       out  1            fetch request; held high until imem_ack
//  imem_addr      out  PC_WIDTH     fetch address; stable while imem_req=1
//  imem_ack       in   1            response valid this cycle (same cycle as req allowed)
//  imem_rdata     in   INSTR_WIDTH  instruction word, valid with imem_ack
//  instr_f        out  INSTR_WIDTH  fetched instruction (registered)
//  pc_f           out  PC_WIDTH     address of instr_f
//  pc_plus_8_f    out  PC_WIDTH     pc_f + 8 (mod 2^PC_WIDTH)
//  valid_f        out  1            output slot holds a live instruction
// BEHAVIOUR
//  - Registers:
//    - pc_q: next PC to fetch.
//    - addr_q: in-flight address; imem_addr = addr_q.
//    - Output slot: instr_f, pc_f, pc_plus_8_f, valid_f.
//    - state: S_RESET, S_IDLE, S_BUSY, S_DRAIN.
//  - Reset values:
//    - pc_q=RESET_PC, addr_q=RESET_PC, state=S_RESET.
//    - All output-slot regs = 0, so imem_req=0.
//  - imem_req = (state==S_BUSY || state==S_DRAIN); purely a state decode.
//  - slot_free = ~valid_f | ~stall_f. The slot is consumed at any edge where valid_f=1 and stall_f=0.
//  - State transitions:
//    - S_RESET -> S_IDLE unconditionally (one dead cycle after reset release).
//    - S_IDLE -> S_BUSY when slot_free and ~redirect_d; addr_q <= pc_q.
//    - S_BUSY + imem_ack + ~redirect_d: capture slot {imem_rdata, addr_q, addr_q+8, 1}; pc_q <= addr_q+PC_STEP; -> S_IDLE.
//    - S_BUSY + ~imem_ack + redirect_d: -> S_DRAIN (response will be squashed).
//    - S_DRAIN + imem_ack: data discarded; -> S_IDLE.
//  - Redirect, in any state, has priority over stall and ack:
//    - pc_q <= {redirect_pc_d[PC_WIDTH-1:2], 2'b00}.
//    - valid_f <= 0.
//    - An ack in the same cycle is discarded, state -> S_IDLE.
//    - Redirect in S_DRAIN updates pc_q again (the last target wins).
//  - Slot update when no capture and no redirect: a consumed slot clears valid_f; a stalled slot holds all values.
//  - Throughput: at most one fetch per 2 cycles. Exactly one request is ever outstanding, so a captured word always finds the slot empty and no skid buffer is needed.
//  - PC arithmetic wraps modulo 2^PC_WIDTH, e.g. pc 0xFFFFFFFC -> next 0x00000000, pc_plus_8 0x00000004.
//  - Reset mid-request: imem_req drops immediately (async); the memory side must tolerate an abandoned request.
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined:
//    - Adds outputs perf_fetch_cnt[31:0] (+1 per capture into the slot) and perf_stall_cnt[31:0] (+1 per cycle with valid_f & stall_f).
//    - Both counters reset to 0 and wrap at 2^32.
//  - Undefined: neither port exists and no counter logic is generated.
// STRUCTURE
//  - Shared package pipeline_pkg: PC_WIDTH, INSTR_WIDTH, RESET_PC defaults, fetch state encoding.
//  - Optional sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN. All else is inline.
// TESTING
//  1. Reset, zero-wait memory, no stall:
//     - imem_addr sequence 0x0,0x4,0x8; req on alternate cycles.
//     - pc_f=0x0/instr_f=mem[0], pc_plus_8_f=0x8.
//  2. stall_f=1 for 5 cycles with a slot valid at pc 0x4:
//     - Slot holds 0x4 unchanged; no new imem_req until stall_f drops.
//  3. Memory ack delayed 3 cycles:
//     - imem_req/imem_addr=0x8 stable for all 4 cycles; capture only on ack.
//  4. redirect_d to 0x100 while S_BUSY at 0xC with ack 2 cycles later:
//     - valid_f=0 next cycle; the 0xC data is dropped; next imem_addr=0x100.
//  5. redirect_d to 0x203 in the same cycle as ack:
//     - Data dropped; next fetch at 0x200.
//     - With stall_f=1, valid_f still clears.
//  6. Fetch at 0xFFFFFFFC:
//     - pc_plus_8_f=0x4; next imem_addr=0x0.
//     - With FETCH_PERF_CNT_EN: the counters match the captures and stall cycles across tests 1-5.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline defaults and fetch-stage state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  // Default datapath widths and reset fetch address
  localparam int unsigned      PC_WIDTH_DEFAULT    = 32;
  localparam int unsigned      INSTR_WIDTH_DEFAULT = 32;
  localparam logic [31:0]      RESET_PC_DEFAULT    = 32'h0000_0000;

  // Fetch controller state encoding
  typedef logic [1:0] fetch_state_t;

  localparam logic [1:0] S_RESET = 2'd0;  // one dead cycle after reset release
  localparam logic [1:0] S_IDLE  = 2'd1;  // no request outstanding
  localparam logic [1:0] S_BUSY  = 2'd2;  // request outstanding, response wanted
  localparam logic [1:0] S_DRAIN = 2'd3;  // request outstanding, response squashed

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory req/ack bus between fetch and memory.
//                The master (fetch) holds req and addr until ack; the slave
//                may return ack in the same cycle as req.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEFAULT
);

  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_perf_cnt
//  Description : Free-running fetch/stall event counters, wrap at 2^32.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_perf_cnt (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        fetch_evt_i,   // one word captured into the slot
  input  wire logic        stall_evt_i,   // slot valid and held this cycle
  output logic [31:0]      perf_fetch_cnt_o,
  output logic [31:0]      perf_stall_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Increment each counter on its event; natural wrap at 2^32
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (fetch_evt_i ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + (stall_evt_i ? 32'd1 : 32'd0);
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;

endmodule : fetch_perf_cnt
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : IF stage feeding the IF/ID register. Owns the fetch PC,
//                keeps exactly one instruction-memory request in flight and
//                presents {instr_f, pc_f, pc_plus_8_f, valid_f}. ID-stage
//                redirects flush the slot and squash any in-flight response.
//                Optional build macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt
//                and perf_stall_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int unsigned          INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int unsigned          PC_STEP     = 4
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   stall_f,
  input  wire logic                   redirect_d,
  input  wire logic [PC_WIDTH-1:0]    redirect_pc_d,
  fetch_stage_if.master               imem,
  output logic [INSTR_WIDTH-1:0]      instr_f,
  output logic [PC_WIDTH-1:0]         pc_f,
  output logic [PC_WIDTH-1:0]         pc_plus_8_f,
  output logic                        valid_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_fetch_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  localparam logic [PC_WIDTH-1:0] c_pc_step  = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] c_pc_eight = PC_WIDTH'(8);
  localparam logic [PC_WIDTH-1:0] c_align    = ~PC_WIDTH'(3);

  fetch_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcf_q, pcf_d;
  logic [PC_WIDTH-1:0]    pc8_q, pc8_d;
  logic                   valid_q, valid_d;

  logic                   slot_free;
  logic                   capture;
  logic [PC_WIDTH-1:0]    redirect_tgt;

  // Slot can accept a new word if it is empty or being consumed this edge
  assign slot_free    = ~valid_q | ~stall_f;
  // A response lands in the slot only when it is wanted and not squashed
  assign capture      = (state_q == S_BUSY) & imem.imem_ack & ~redirect_d;
  // Redirect targets are word aligned; the low two bits are dropped
  assign redirect_tgt = redirect_pc_d & c_align;

  // Next-state, PC and output-slot update; redirect applied last so it wins
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    pcf_d   = pcf_q;
    pc8_d   = pc8_q;
    valid_d = valid_q & stall_f;   // consumed slot empties, stalled slot holds

    case (state_q)
      S_RESET: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (slot_free && !redirect_d) begin
          state_d = S_BUSY;
          addr_d  = pc_q;
        end
      end
      S_BUSY: begin
        if (imem.imem_ack) begin
          state_d = S_IDLE;
        end else if (redirect_d) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem.imem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      instr_d = imem.imem_rdata;
      pcf_d   = addr_q;
      pc8_d   = addr_q + c_pc_eight;
      valid_d = 1'b1;
      pc_d    = addr_q + c_pc_step;
    end

    if (redirect_d) begin
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
    end
  end

  // State, PC and output-slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      pcf_q   <= '0;
      pc8_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
    end
  end

  // Request is a pure state decode so reset drops it immediately
  assign imem.imem_req  = (state_q == S_BUSY) || (state_q == S_DRAIN);
  assign imem.imem_addr = addr_q;

  assign instr_f     = instr_q;
  assign pc_f        = pcf_q;
  assign pc_plus_8_f = pc8_q;
  assign valid_f     = valid_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk              (clk),
    .reset            (reset),
    .fetch_evt_i      (capture),
    .stall_evt_i      (valid_q & stall_f),
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed bench for fetch_stage with a latency-programmable
//                instruction memory returning {16'hC0DE, addr[15:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        redirect_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus_8_f;
  logic        valid_f;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_f       (stall_f),
    .redirect_d    (redirect_d),
    .redirect_pc_d (redirect_pc_d),
    .imem          (imem_bus.master),
    .instr_f       (instr_f),
    .pc_f          (pc_f),
    .pc_plus_8_f   (pc_plus_8_f),
    .valid_f       (valid_f)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: ack once the request has waited ack_lat cycles
  logic [7:0] ack_lat;
  logic [7:0] wait_cnt;

  assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt == ack_lat);
  assign imem_bus.imem_rdata = {16'hC0DE, imem_bus.imem_addr[15:0]};

  always @(posedge clk or posedge reset) begin
    if (reset)                                       wait_cnt <= 8'd0;
    else if (!imem_bus.imem_req || imem_bus.imem_ack) wait_cnt <= 8'd0;
    else                                             wait_cnt <= wait_cnt + 8'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    stall_f       = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = 32'h0;
    ack_lat       = 8'd0;
    tick();
    tick();

    // Reset state
    check_eq("rst_req",   32'(imem_bus.imem_req), 32'h0);
    check_eq("rst_addr",  imem_bus.imem_addr,     32'h0);
    check_eq("rst_valid", 32'(valid_f),           32'h0);
    check_eq("rst_pc_f",  pc_f,                   32'h0);
    check_eq("rst_instr", instr_f,                32'h0);
    check_eq("rst_pc8",   pc_plus_8_f,            32'h0);

    // Test 1: zero-wait memory, no stall
    reset = 1'b0;
    tick();                                                   // dead cycle
    check_eq("t1_dead_req", 32'(imem_bus.imem_req), 32'h0);
    tick();
    check_eq("t1_req0",  32'(imem_bus.imem_req), 32'h1);
    check_eq("t1_addr0", imem_bus.imem_addr,     32'h0);
    tick();
    check_eq("t1_valid0", 32'(valid_f),           32'h1);
    check_eq("t1_pc_f0",  pc_f,                   32'h0);
    check_eq("t1_instr0", instr_f,                32'hC0DE_0000);
    check_eq("t1_pc8_0",  pc_plus_8_f,            32'h8);
    check_eq("t1_gap",    32'(imem_bus.imem_req), 32'h0);
    tick();
    check_eq("t1_req4",   32'(imem_bus.imem_req), 32'h1);
    check_eq("t1_addr4",  imem_bus.imem_addr,     32'h4);
    check_eq("t1_consume",32'(valid_f),           32'h0);

    // Test 2: stall for 5 cycles with the 0x4 word in the slot
    stall_f = 1'b1;
    tick();
    check_eq("t2_valid", 32'(valid_f),           32'h1);
    check_eq("t2_pc_f",  pc_f,                   32'h4);
    check_eq("t2_pc8",   pc_plus_8_f,            32'hC);
    check_eq("t2_noreq", 32'(imem_bus.imem_req), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_hold_pc",  pc_f,                   32'h4);
      check_eq("t2_hold_v",   32'(valid_f),           32'h1);
      check_eq("t2_hold_req", 32'(imem_bus.imem_req), 32'h0);
    end

    // Test 3: ack delayed 3 cycles, request held for 4 cycles
    stall_f = 1'b0;
    ack_lat = 8'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t3_req",   32'(imem_bus.imem_req), 32'h1);
      check_eq("t3_addr",  imem_bus.imem_addr,     32'h8);
      check_eq("t3_valid", 32'(valid_f),           32'h0);
    end
    tick();
    check_eq("t3_cap_v",     32'(valid_f), 32'h1);
    check_eq("t3_cap_pc",    pc_f,         32'h8);
    check_eq("t3_cap_instr", instr_f,      32'hC0DE_0008);

    // Test 4: redirect to 0x100 while busy at 0xC, ack 2 cycles later
    ack_lat = 8'd2;
    tick();
    check_eq("t4_addrC", imem_bus.imem_addr,     32'hC);
    check_eq("t4_reqC",  32'(imem_bus.imem_req), 32'h1);
    redirect_d    = 1'b1;
    redirect_pc_d = 32'h100;
    tick();
    redirect_d    = 1'b0;
    check_eq("t4_valid",   32'(valid_f),           32'h0);
    check_eq("t4_drain_r", 32'(imem_bus.imem_req), 32'h1);
    check_eq("t4_drain_a", imem_bus.imem_addr,     32'hC);
    tick();
    check_eq("t4_drain_r2", 32'(imem_bus.imem_req), 32'h1);
    tick();
    check_eq("t4_dropped", 32'(valid_f),           32'h0);
    check_eq("t4_idle",    32'(imem_bus.imem_req), 32'h0);
    ack_lat = 8'd0;
    tick();
    check_eq("t4_new_addr", imem_bus.imem_addr,     32'h100);
    check_eq("t4_new_req",  32'(imem_bus.imem_req), 32'h1);
    tick();
    check_eq("t4_cap_pc",    pc_f,         32'h100);
    check_eq("t4_cap_instr", instr_f,      32'hC0DE_0100);
    check_eq("t4_cap_pc8",   pc_plus_8_f,  32'h108);

    // Test 5: redirect to 0x203 in the same cycle as ack, stall asserted
    tick();
    check_eq("t5_addr104", imem_bus.imem_addr, 32'h104);
    redirect_d    = 1'b1;
    redirect_pc_d = 32'h203;
    stall_f       = 1'b1;
    tick();
    redirect_d    = 1'b0;
    check_eq("t5_dropped", 32'(valid_f),           32'h0);
    check_eq("t5_idle",    32'(imem_bus.imem_req), 32'h0);
    tick();
    check_eq("t5_addr200", imem_bus.imem_addr,     32'h200);
    check_eq("t5_req200",  32'(imem_bus.imem_req), 32'h1);
    tick();
    check_eq("t5_cap_v",  32'(valid_f), 32'h1);
    check_eq("t5_cap_pc", pc_f,         32'h200);
    check_eq("t5_instr",  instr_f,      32'hC0DE_0200);
    redirect_d    = 1'b1;
    redirect_pc_d = 32'hFFFF_FFFF;
    tick();
    redirect_d    = 1'b0;
    stall_f       = 1'b0;
    check_eq("t5_stall_clr", 32'(valid_f), 32'h0);

    // Test 6: fetch at the top of the address space
    tick();
    check_eq("t6_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("t6_pc_f",  pc_f,        32'hFFFF_FFFC);
    check_eq("t6_pc8",   pc_plus_8_f, 32'h4);
    check_eq("t6_instr", instr_f,     32'hC0DE_FFFC);
    tick();
    check_eq("t6_wrap_addr", imem_bus.imem_addr,     32'h0);
    check_eq("t6_wrap_req",  32'(imem_bus.imem_req), 32'h1);

`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt, 32'd6);
    check_eq("perf_stall", perf_stall_cnt, 32'd5);
`endif

    // Reset while a request is outstanding drops req without a clock edge
    reset = 1'b1;
    #1;
    check_eq("rst_mid_req",   32'(imem_bus.imem_req), 32'h0);
    check_eq("rst_mid_valid", 32'(valid_f),           32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
